// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment driver: scans BCD digits from a display register,
// one slot of DIV clocks per digit, with optional leading-zero blanking.
`timescale 1ns/1ps

module seg7_scan #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_disp;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_frame;

    logic          w_tick;
    logic [3:0]    w_nib;
    logic [3:0]    w_nz;
    logic [3:0]    w_upper_nz;
    logic          w_blank;
    logic [6:0]    w_pat;
    logic [3:0]    w_an;

    assign w_tick = (r_cnt == LAST);

    // NOTE: all state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
        end
    end

    // Frame marks the edge where the scan index wraps 3 -> 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_tick && (r_idx == 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_disp <= 16'h0000;
        end else if (load) begin
            r_disp <= value;
        end
    end

    // Per-digit nonzero flags, then "this digit or any higher one is nonzero".
    always_comb begin
        w_nz[0] = |r_disp[3:0];
        w_nz[1] = |r_disp[7:4];
        w_nz[2] = |r_disp[11:8];
        w_nz[3] = |r_disp[15:12];
        w_upper_nz[3] = w_nz[3];
        w_upper_nz[2] = w_nz[3] | w_nz[2];
        w_upper_nz[1] = w_nz[3] | w_nz[2] | w_nz[1];
        w_upper_nz[0] = 1'b1;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_nib = r_disp[3:0];
        case (r_idx)
            2'd1:    w_nib = r_disp[7:4];
            2'd2:    w_nib = r_disp[11:8];
            2'd3:    w_nib = r_disp[15:12];
            default: w_nib = r_disp[3:0];
        endcase
    end

    always_comb begin
        w_pat = SEG_DASH;
        case (w_nib)
            4'd0:    w_pat = 7'b1000000;
            4'd1:    w_pat = 7'b1111001;
            4'd2:    w_pat = 7'b0100100;
            4'd3:    w_pat = 7'b0110000;
            4'd4:    w_pat = 7'b0011001;
            4'd5:    w_pat = 7'b0010010;
            4'd6:    w_pat = 7'b0000010;
            4'd7:    w_pat = 7'b1111000;
            4'd8:    w_pat = 7'b0000000;
            4'd9:    w_pat = 7'b0010000;
            default: w_pat = SEG_DASH;
        endcase
    end

    assign w_blank = blank_lz && !w_upper_nz[r_idx];
    assign w_an    = ~(4'b0001 << r_idx);

    // Anode and segments are registered together from the same index and display
    // value, so a mid-slot load never shows another digit's pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an;
            r_seg <= w_blank ? SEG_BLANK : w_pat;
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan: an edge-count reference model checked every cycle,
// plus hand-computed scenarios for scan order, decoding, blanking and reset.
`timescale 1ns/1ps

module tb_seg7_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    always #5 clk = ~clk;

    seg7_scan #(.DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .frame    (frame)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs follow from the number of edges since reset.
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    function automatic logic [6:0] digit_pattern(input logic [15:0] d, input int k, input logic blz);
        int nib;
        nib = int'((d >> (4 * k)) & 16'h000F);
        if (blz && k > 0 && (d >> (4 * k)) == 16'h0000) return 7'h7F;
        return seg_tbl[nib];
    endfunction

    int          mk = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_frame;
    logic        valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mk        <= 0;
            m_disp    <= 16'h0000;
            exp_an    <= 4'hF;
            exp_seg   <= 7'h7F;
            exp_frame <= 1'b0;
            valid     <= 1'b1;
        end else if (valid) begin
            exp_an    <= ~(4'b0001 << ((mk / DIV) % 4));
            exp_seg   <= digit_pattern(m_disp, (mk / DIV) % 4, blank_lz);
            exp_frame <= (mk % (4 * DIV)) == (4 * DIV - 1);
            if (load) m_disp <= value;
            mk <= mk + 1;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            check("model_an", an, exp_an);
            check("model_seg", seg, exp_seg);
            check("model_frame", frame, exp_frame);
        end
    end

    task automatic show_digit(input string name, input int k, input logic [6:0] pat);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << k);
        n = 0;
        @(negedge clk);
        while (an !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (an !== want) check({name, "_timeout"}, an, want);
        else check(name, seg, pat);
    endtask

    task automatic load_value(input logic [15:0] v, input logic blz);
        load = 1'b1;
        value = v;
        blank_lz = blz;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [3:0] an_seq [16] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1101, 4'b1101,
                                4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111, 4'b0111};

    initial begin
        int n;
        int zc;
        reset = 1'b1;
        load = 1'b0;
        value = 16'h0000;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_frame", frame, 1'b0);
        reset = 1'b0;

        // Idle scan: anode order, slot length and frame spacing.
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check("scan_an", an, an_seq[(i - 1) % 16]);
            check("scan_frame", frame, (i % 16) == 0);
            if (i == 1) check("first_seg", seg, 7'b1000000);
        end

        load_value(16'h1234, 1'b0);
        show_digit("d0_1234", 0, 7'b0011001);
        show_digit("d1_1234", 1, 7'b0110000);
        show_digit("d2_1234", 2, 7'b0100100);
        show_digit("d3_1234", 3, 7'b1111001);

        load_value(16'h0070, 1'b1);
        show_digit("d3_0070_blz", 3, 7'b1111111);
        show_digit("d2_0070_blz", 2, 7'b1111111);
        show_digit("d1_0070_blz", 1, 7'b1111000);
        show_digit("d0_0070_blz", 0, 7'b1000000);
        load_value(16'h0070, 1'b0);
        show_digit("d3_0070", 3, 7'b1000000);
        show_digit("d2_0070", 2, 7'b1000000);

        load_value(16'hF0A5, 1'b0);
        show_digit("d3_F0A5", 3, 7'b0111111);
        show_digit("d2_F0A5", 2, 7'b1000000);
        show_digit("d1_F0A5", 1, 7'b0111111);
        show_digit("d0_F0A5", 0, 7'b0010010);
        load_value(16'hF0A5, 1'b1);
        show_digit("d2_F0A5_blz", 2, 7'b1000000);
        show_digit("d3_F0A5_blz", 3, 7'b0111111);

        // Reset wins over a simultaneous load.
        blank_lz = 1'b0;
        reset = 1'b1;
        load = 1'b1;
        value = 16'h9999;
        @(negedge clk);
        check("rstld_an", an, 4'b1111);
        check("rstld_seg", seg, 7'b1111111);
        reset = 1'b0;
        load = 1'b0;
        @(negedge clk);
        check("rstld_rel_an", an, 4'b1110);
        check("rstld_rel_seg", seg, 7'b1000000);

        // Reset during digit 2 restarts a full slot at digit 0.
        n = 0;
        while (an !== 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_idx2", an, 4'b1011);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_an", an, 4'b1111);
        reset = 1'b0;
        @(negedge clk);
        n = 0;
        while (an === 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_slot_len", n, DIV);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 7) == 0);
            zc = $urandom_range(0, 4);
            value = 16'($urandom) & (16'hFFFF >> (4 * zc));
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
